fifo_wptr_ctrl: RTL and testbench

FIFO_WPTR_CTRL -- requirements
Module: fifo_wptr_ctrl

---
 rtl/fifo_wptr_ctrl.sv | 158 +++++++++++++++
 tb/tb_fifo_wptr_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wptr_ctrl
//
// Purpose:
//   Write-side pointer controller for an asynchronous FIFO. It keeps the binary
//   write pointer, publishes a registered Gray copy to the read domain, and
//   synchronizes the read domain's Gray pointer into this clock domain. From
//   these it drives the memory write enable and address, the registered full
//   flag, and the fill level as seen from the write side.
//
// Optional feature (compile-time macro FIFO_WPTR_AF_EN):
//   When defined, a registered almost_full_o port is added. It is set when the
//   next fill level is at least AF_THRESH. When the macro is undefined the port
//   and its logic do not exist, and all other behaviour is unchanged.
//
// Parameters:
//   DEPTH        FIFO entry count. Must be a power of two and at least 4.
//   SYNC_STAGES  Number of synchronizer flops on the read pointer, at least 2.
//   AF_THRESH    Almost-full level. Only used with FIFO_WPTR_AF_EN.
//
// Ports:
//   clk_i          write-domain clock
//   rst_i          asynchronous active-high reset; release must be synchronous
//   winc_i         write request for the current cycle
//   rptr_gray_i    read-domain Gray pointer (AW+1 bits, unsynchronized)
//   wen_o          memory write enable, equal to winc_i & ~full_o
//   waddr_o        memory write address (AW bits)
//   wptr_gray_o    registered Gray write pointer for the read domain
//   full_o         registered FIFO-full flag
//   wcount_o       fill level from the write domain, 0..DEPTH
//   almost_full_o  registered almost-full flag (FIFO_WPTR_AF_EN only)
// -----------------------------------------------------------------------------
module fifo_wptr_ctrl #(
  parameter int DEPTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = DEPTH - 4,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          winc_i,
  input  logic [AW:0]   rptr_gray_i,
  output logic          wen_o,
  output logic [AW-1:0] waddr_o,
  output logic [AW:0]   wptr_gray_o,
  output logic          full_o,
  output logic [AW:0]   wcount_o
`ifdef FIFO_WPTR_AF_EN
  ,
  output logic          almost_full_o
`endif
);

  // Parameter sanity. This is evaluated at elaboration and produces no hardware.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (SYNC_STAGES < 2) ||
      (AF_THRESH < 0) || (AF_THRESH > DEPTH)) begin : g_bad_param
    $error("fifo_wptr_ctrl: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AW:0] wbin_q,  wbin_d;
  logic [AW:0] wgray_q, wgray_d;
  logic        full_q,  full_d;
  logic [AW:0] sync_q [SYNC_STAGES];
  logic [AW:0] sync_d [SYNC_STAGES];

  logic [AW:0] rq_sync;
  logic [AW:0] rbin_sync;
  logic        wen;
  logic [AW:0] full_gray;

  // ---------------------------------------------------------------------------
  // Read-pointer synchronizer and Gray-to-binary conversion
  // ---------------------------------------------------------------------------
  always_comb begin
    sync_d[0] = rptr_gray_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign rq_sync = sync_q[SYNC_STAGES-1];

  // Binary bit k is the XOR of all Gray bits at position k and above.
  for (genvar gi = 0; gi <= AW; gi++) begin : g_g2b
    assign rbin_sync[gi] = ^(rq_sync >> gi);
  end

  // ---------------------------------------------------------------------------
  // Write pointer and full flag
  // ---------------------------------------------------------------------------
  assign wen = winc_i & ~full_q;

  // The Gray pointer is exactly DEPTH ahead of the read pointer when its two
  // MSBs are the inverse of the read pointer's and the rest match.
  assign full_gray = {~rq_sync[AW:AW-1], rq_sync[AW-2:0]};

  always_comb begin
    wbin_d  = wbin_q + {{AW{1'b0}}, wen};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    // Compare the pointer after this edge against the synchronized read
    // pointer, so full rises on the same edge that accepts the last free slot.
    full_d  = (wgray_d == full_gray);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional almost-full flag
  // ---------------------------------------------------------------------------
`ifdef FIFO_WPTR_AF_EN
  logic        af_q, af_d;
  logic [AW:0] wcount_next;

  always_comb begin
    wcount_next = wbin_d - rbin_sync;
    af_d        = (int'(wcount_next) >= AF_THRESH);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign almost_full_o = af_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wen_o       = wen;
  assign waddr_o     = wbin_q[AW-1:0];
  assign wptr_gray_o = wgray_q;
  assign full_o      = full_q;
  assign wcount_o    = wbin_q - rbin_sync;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wptr_ctrl
//
// Self-checking bench for fifo_wptr_ctrl with DEPTH=32 and SYNC_STAGES=2. The
// reference model tracks the total number of accepted writes and the read
// position modulo 64. The synchronizer is modelled as a two-entry delay queue
// of read positions. Full is defined as "writes minus synchronized reads equals
// DEPTH", and the fill level is the plain modular difference.
// -----------------------------------------------------------------------------
module tb_fifo_wptr_ctrl;
  localparam int DEPTH = 32;
  localparam int SYNC  = 2;
  localparam int AF    = 28;
  localparam int AW    = 5;
  localparam int MODW  = 64;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          winc_i;
  logic [AW:0]   rptr_gray_i;
  logic          wen_o;
  logic [AW-1:0] waddr_o;
  logic [AW:0]   wptr_gray_o;
  logic          full_o;
  logic [AW:0]   wcount_o;
`ifdef FIFO_WPTR_AF_EN
  logic          almost_full_o;
`endif

  fifo_wptr_ctrl #(
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SYNC),
    .AF_THRESH  (AF)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .winc_i       (winc_i),
    .rptr_gray_i  (rptr_gray_i),
    .wen_o        (wen_o),
    .waddr_o      (waddr_o),
    .wptr_gray_o  (wptr_gray_o),
    .full_o       (full_o),
    .wcount_o     (wcount_o)
`ifdef FIFO_WPTR_AF_EN
    ,
    .almost_full_o(almost_full_o)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_wr;       // accepted writes modulo 64
  int m_rd;       // read position modulo 64 currently driven
  bit m_full;
  bit m_af;
  int m_sync[$];  // read positions in flight; [0] is the synchronized one

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int exp_count();
    return (m_wr - m_sync[0]) & (MODW - 1);
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_full = 1'b0; m_af = 1'b0;
    m_sync = {};
    for (int i = 0; i < SYNC; i++) m_sync.push_back(0);
  endtask

  // Drive inputs for the coming edge and let combinational outputs settle.
  task automatic drive(input bit w, input int r);
    winc_i      = w;
    m_rd        = r & (MODW - 1);
    rptr_gray_i = to_gray(m_rd);
    #1;
  endtask

  // Advance one clock edge and update the model, then settle.
  task automatic tick();
    bit acc;
    int cnt;
    @(posedge clk);
    if (!rst_i) begin
      acc = winc_i && !m_full;
      if (acc) m_wr = (m_wr + 1) & (MODW - 1);
      cnt    = (m_wr - m_sync[0]) & (MODW - 1);
      m_full = (cnt == DEPTH);
      m_af   = (cnt >= AF);
      void'(m_sync.pop_front());
      m_sync.push_back(m_rd);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    drive(0, 0);
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    model_reset();
    drive(1, 0);
    checks++;
    if (wen_o !== 1'b1) begin failures++; $display("FAIL rst_wen_follows got=%0b exp=1", wen_o); end
    checks++;
    if (waddr_o !== '0 || wptr_gray_o !== '0 || wcount_o !== '0 || full_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_values got addr=%0d gray=%0h cnt=%0d full=%0b exp all 0", waddr_o, wptr_gray_o, wcount_o, full_o);
    end
`ifdef FIFO_WPTR_AF_EN
    checks++;
    if (almost_full_o !== 1'b0) begin failures++; $display("FAIL rst_af got=%0b exp=0", almost_full_o); end
`endif
    tick();
    drive(0, 0);
    checks++;
    if (wen_o !== 1'b0) begin failures++; $display("FAIL rst_wen_low got=%0b exp=0", wen_o); end
    tick();
    rst_i = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_fill();
    logic [AW:0] g_full;
    g_full = 6'b110000;
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, 0);
      checks++;
      if (wen_o !== 1'b1) begin failures++; $display("FAIL fill_wen k=%0d got=%0b exp=1", k, wen_o); end
      tick();
      checks++;
      if (full_o !== (k == DEPTH - 1)) begin failures++; $display("FAIL fill_full k=%0d got=%0b exp=%0b", k, full_o, k == DEPTH - 1); end
`ifdef FIFO_WPTR_AF_EN
      checks++;
      if (almost_full_o !== (k >= AF - 1)) begin failures++; $display("FAIL fill_af k=%0d got=%0b exp=%0b", k, almost_full_o, k >= AF - 1); end
`endif
    end
    checks++;
    if (wcount_o !== 6'd32) begin failures++; $display("FAIL fill_count got=%0d exp=32", wcount_o); end
    checks++;
    if (wptr_gray_o !== g_full) begin failures++; $display("FAIL fill_gray got=%b exp=%b", wptr_gray_o, g_full); end
    checks++;
    if (waddr_o !== 5'd0) begin failures++; $display("FAIL fill_addr got=%0d exp=0", waddr_o); end
    $display("test_fill done wcount=%0d", wcount_o);
  endtask

  task automatic test_full_hold();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0);
      checks++;
      if (wen_o !== 1'b0) begin failures++; $display("FAIL hold_wen k=%0d got=%0b exp=0", k, wen_o); end
      tick();
      checks++;
      if (waddr_o !== 5'd0 || wptr_gray_o !== 6'b110000 || full_o !== 1'b1) begin
        failures++;
        $display("FAIL hold_state k=%0d got addr=%0d gray=%b full=%0b exp 0/110000/1", k, waddr_o, wptr_gray_o, full_o);
      end
    end
    $display("test_full_hold done");
  endtask

  task automatic test_release();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1);
      tick();
      checks++;
      if (full_o !== (k < 2)) begin failures++; $display("FAIL release_full edge=%0d got=%0b exp=%0b", k + 1, full_o, k < 2); end
    end
    checks++;
    if (wcount_o !== 6'd31) begin failures++; $display("FAIL release_count got=%0d exp=31", wcount_o); end
    // One slot is free: the next write is accepted and fills the FIFO again.
    drive(1, 1);
    checks++;
    if (wen_o !== 1'b1) begin failures++; $display("FAIL refill_wen got=%0b exp=1", wen_o); end
    tick();
    checks++;
    if (full_o !== 1'b1 || waddr_o !== 5'd1) begin
      failures++;
      $display("FAIL refill_state got full=%0b addr=%0d exp 1/1", full_o, waddr_o);
    end
    $display("test_release done");
  endtask

  task automatic test_stream();
    int wrote;
    int wraps;
    logic [AW-1:0] prev;
    do_reset();
    wrote = 0;
    wraps = 0;
    prev  = waddr_o;
    for (int k = 0; k < 70; k++) begin
      drive(1, (wrote > 4) ? wrote - 4 : 0);
      checks++;
      if (wen_o !== 1'b1) begin failures++; $display("FAIL stream_wen k=%0d got=%0b exp=1", k, wen_o); end
      tick();
      wrote++;
      checks++;
      if (full_o !== 1'b0 || waddr_o !== (wrote & (DEPTH - 1)) || wcount_o !== exp_count()) begin
        failures++;
        $display("FAIL stream_state k=%0d got full=%0b addr=%0d cnt=%0d exp 0/%0d/%0d", k, full_o, waddr_o, wcount_o, wrote & (DEPTH - 1), exp_count());
      end
      if (prev == 5'd31 && waddr_o == 5'd0) wraps++;
      prev = waddr_o;
    end
    checks++;
    if (wraps !== 2) begin failures++; $display("FAIL stream_wraps got=%0d exp=2", wraps); end
    checks++;
    if (wptr_gray_o !== to_gray(70)) begin failures++; $display("FAIL stream_gray got=%b exp=%b", wptr_gray_o, to_gray(70)); end
    $display("test_stream done wrote=%0d wraps=%0d", wrote, wraps);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1, 0);
      tick();
    end
    checks++;
    if (wcount_o !== 6'd17) begin failures++; $display("FAIL areset_pre_count got=%0d exp=17", wcount_o); end
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if (wptr_gray_o !== '0 || waddr_o !== '0 || wcount_o !== '0 || full_o !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate got gray=%0h addr=%0d cnt=%0d full=%0b exp all 0", wptr_gray_o, waddr_o, wcount_o, full_o);
    end
    drive(0, 0);
    tick();
    rst_i = 1'b0;
    drive(1, 0);
    checks++;
    if (wen_o !== 1'b1 || waddr_o !== 5'd0) begin failures++; $display("FAIL areset_first_write got wen=%0b addr=%0d exp 1/0", wen_o, waddr_o); end
    tick();
    checks++;
    if (waddr_o !== 5'd1 || wcount_o !== 6'd1) begin failures++; $display("FAIL areset_after got addr=%0d cnt=%0d exp 1/1", waddr_o, wcount_o); end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    bit w;
    int r;
    int read_pct;
    int full_seen;
    do_reset();
    full_seen = 0;
    for (int k = 0; k < 600; k++) begin
      read_pct = (k < 300) ? 30 : 70;
      w = ($urandom_range(99) < 75);
      r = m_rd;
      if (((m_wr - m_rd) & (MODW - 1)) != 0 && $urandom_range(99) < read_pct) r = m_rd + 1;
      drive(w, r);
      checks++;
      if (wen_o !== (w && !m_full)) begin failures++; $display("FAIL rand_wen k=%0d got=%0b exp=%0b", k, wen_o, w && !m_full); end
      tick();
      if (m_full) full_seen++;
      checks++;
      if (full_o !== m_full || wcount_o !== exp_count() || waddr_o !== (m_wr & (DEPTH - 1)) || wptr_gray_o !== to_gray(m_wr)) begin
        failures++;
        $display("FAIL rand_state k=%0d got full=%0b cnt=%0d addr=%0d gray=%0h exp %0b/%0d/%0d/%0h",
                 k, full_o, wcount_o, waddr_o, wptr_gray_o, m_full, exp_count(), m_wr & (DEPTH - 1), to_gray(m_wr));
      end
`ifdef FIFO_WPTR_AF_EN
      checks++;
      if (almost_full_o !== m_af) begin failures++; $display("FAIL rand_af k=%0d got=%0b exp=%0b", k, almost_full_o, m_af); end
`endif
    end
    $display("test_random done full_cycles=%0d", full_seen);
  endtask

  initial begin
    rst_i       = 1'b1;
    winc_i      = 1'b0;
    rptr_gray_i = '0;
    model_reset();
    test_reset();
    test_fill();
    test_full_hold();
    test_release();
    test_stream();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "timeout");
  end

endmodule
